reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Register-file write scoreboard for the pipelined CPU. It tracks outstanding writes per architectural register and stalls decode/issue on RAW hazards and counter saturation. Writeback and squash ports retire pending writes. It sits beside the 32x64 register file, between decode and the pipeline stage registers, and gates the issue of each instruction that reads or writes that file.

## Interface
Parameters:
- REGS, 32, architectural register count; index 31 is the hardwired-zero register.
- CNT_W, 2, width of each per-register pending counter. Max outstanding writes per register = 2^CNT_W − 1.
- TOT_W, 7, width of the total outstanding counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- issue_valid  in  1  decode presents an instruction.
- issue_rs1, issue_rs2  in  5  source register indices.
- issue_rs1_used, issue_rs2_used  in  1  source actually read.
- issue_rd  in  5  destination index.
- issue_rd_we  in  1  instruction writes issue_rd.
- issue_ready  out  1  instruction may issue this cycle (combinational).
- wb_valid  in  1  writeback of one register this cycle.
- wb_rd  in  5  register being written back.
- kill_valid  in  1  a squashed instruction that had issue_rd_we=1 leaves the pipe without writing.
- kill_rd  in  5  its destination.
- busy_mask  out  REGS  bit i = count[i] != 0 (registered).
- outstanding  out  TOT_W  sum of all counts (registered).
- err  out  1  sticky protocol error flag.

## Operation
- State: count[i], CNT_W bits, for i = 0..30. count[31] is a constant 0.
- A source is hazardous when it is used, its index is not 31, and count[idx] != 0.
- A destination is blocked when issue_rd_we=1, issue_rd != 31, and count[issue_rd] == max.
- issue_ready = !reset and neither source is hazardous and the destination is not blocked. issue_ready does not depend on issue_valid.
- Issue fires when issue_valid & issue_ready. If issue_rd_we=1 and issue_rd != 31, inc[issue_rd] = 1.
- dec[i] = (wb_valid & wb_rd==i) + (kill_valid & kill_rd==i), so dec ranges over 0..2.
- Next count[i] = count[i] + inc[i] − dec[i]. When an increment and a decrement hit the same register in the same cycle, only the net change is applied.
- Underflow: the decrement exceeds count+inc. The count clamps at 0 and err is set.
- Writes to register 31 (wb, kill, or issue) are ignored. They never set err.
- outstanding tracks the sum of all counts and applies the same net/clamped deltas.
- err clears only on reset.

## Timing
- Reset (sync): on the first edge with reset=1, all counts, busy_mask, outstanding, and err go to 0. While reset=1, issue_ready=0 and the wb/kill/issue inputs are ignored.
- issue_ready is combinational from registered counts and the current issue_* inputs. It has no path from wb_* or kill_*.
- A wb or kill in cycle N releases a stalled consumer in cycle N+1. This matches register-file write-at-edge/read-after behaviour, so no same-cycle bypass exists.
- An issue in cycle N makes its rd hazardous starting in cycle N+1.
- busy_mask and outstanding reflect state after the most recent edge.
- Reset asserted mid-operation discards all pending state. In-flight writes that arrive after reset deasserts are underflows, and they set err.

## Structure
- Package reg_scoreboard_pkg: REG_ZERO = 5'd31, NUM_REGS = 32, typedef reg_idx_t (logic [4:0]), typedef cnt_t (logic [CNT_W-1:0]).
- Sub-module sb_counter: one saturating up-by-1/down-by-0..2 counter with an underflow flag. Instantiate it 31 times in a generate loop, mirroring the per-register generate style of the register file.
- The top level holds the index decode for issue/wb/kill, the ready logic, the outstanding adder, and err.

## Test plan
- Reset, then issue rd=5 (we=1). Next cycle, issue rs1=5 used: issue_ready=0, busy_mask[5]=1, outstanding=1. Then wb_rd=5: ready=1 the cycle after, busy_mask=0, outstanding=0.
- Issue rd=7 three times (CNT_W=2): the fourth issue with rd=7 gets ready=0. Then wb_rd=7 and a same-cycle issue rd=7 are accepted only on the following cycle. The count nets to 3.
- count[9]=1, then wb_rd=9 and kill_rd=9 in the same cycle: count[9]=0, err=1, outstanding=0.
- Issue rd=31 with rs1=31 and rs2=31 used: ready=1 every cycle, busy_mask stays 0. wb_rd=31 with count 0 leaves err=0.
- count[3]=2, then issue rd=3 together with wb_rd=3 in the same cycle: count[3]=2, outstanding unchanged.
- Build three pending registers, assert reset for one cycle: all counts, outstanding, and err are 0, and issue_ready=0 during reset. The next cycle, a source on a previously pending register gets ready=1.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared types and constants for the register-file write scoreboard.
package reg_scoreboard_pkg;
    localparam int NUM_REGS = 32;
    localparam int CNT_W    = 2;

    typedef logic [4:0]       reg_idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam reg_idx_t REG_ZERO = 5'd31;
endpackage

// File: rtl/sb_counter.sv
// One per-register pending-write counter: up by 1, down by 0..2, clamps at 0
// and flags the underflow, saturates at all-ones.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic [1:0]       dec,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] countNext,
    output logic             underflow
);
    import reg_scoreboard_pkg::*;

    localparam int SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] MAX_WIDE = SUM_W'({CNT_W{1'b1}});

    logic [SUM_W-1:0] upSum;
    logic [SUM_W-1:0] decWide;
    logic [SUM_W-1:0] diff;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        upSum     = SUM_W'(count) + SUM_W'(inc);
        decWide   = SUM_W'(dec);
        diff      = upSum - decWide;
        underflow = 1'b0;
        countNext = CNT_W'(diff);
        if (decWide > upSum) begin
            underflow = 1'b1;
            countNext = '0;
        end else if (diff > MAX_WIDE) begin
            countNext = '1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else       count <= countNext;
    end
endmodule

// File: rtl/reg_scoreboard.sv
// Register-file write scoreboard: per-register pending-write counters that
// stall issue on RAW hazards and counter saturation.
module reg_scoreboard #(
    parameter int REGS  = 32,
    parameter int CNT_W = 2,
    parameter int TOT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    input  logic             issue_rs1_used,
    input  logic             issue_rs2_used,
    input  logic [4:0]       issue_rd,
    input  logic             issue_rd_we,
    output logic             issue_ready,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             kill_valid,
    input  logic [4:0]       kill_rd,
    output logic [REGS-1:0]  busy_mask,
    output logic [TOT_W-1:0] outstanding,
    output logic             err
);
    import reg_scoreboard_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [REGS-1:0][CNT_W-1:0] cnt;
    logic [REGS-1:0][CNT_W-1:0] cntNext;
    logic [REGS-1:0]            incVec;
    logic [REGS-1:0]            underflowVec;
    logic [REGS-1:0][1:0]       decVec;
    logic                       rs1Hazard;
    logic                       rs2Hazard;
    logic                       rdBlocked;
    logic                       issueFire;
    logic [TOT_W-1:0]           totalNext;

    assign rs1Hazard   = issue_rs1_used && (issue_rs1 != REG_ZERO) && busy_mask[issue_rs1];
    assign rs2Hazard   = issue_rs2_used && (issue_rs2 != REG_ZERO) && busy_mask[issue_rs2];
    assign rdBlocked   = issue_rd_we && (issue_rd != REG_ZERO) && (cnt[issue_rd] == CNT_MAX);
    assign issue_ready = !reset && !rs1Hazard && !rs2Hazard && !rdBlocked;
    assign issueFire   = issue_valid && issue_ready;

    // The zero register never matches a decode below, so it has no counter.
    for (genvar i = 0; i < REGS - 1; i++) begin : g_reg
        assign incVec[i] = issueFire && issue_rd_we && (issue_rd == reg_idx_t'(i));
        assign decVec[i] = {1'b0, wb_valid   && (wb_rd   == reg_idx_t'(i))}
                         + {1'b0, kill_valid && (kill_rd == reg_idx_t'(i))};

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (incVec[i]),
            .dec       (decVec[i]),
            .count     (cnt[i]),
            .countNext (cntNext[i]),
            .underflow (underflowVec[i])
        );
    end

    assign incVec[REGS-1]       = 1'b0;
    assign decVec[REGS-1]       = '0;
    assign cnt[REGS-1]          = '0;
    assign cntNext[REGS-1]      = '0;
    assign underflowVec[REGS-1] = 1'b0;

    always_comb begin
        totalNext = '0;
        for (int i = 0; i < REGS; i++) begin
            totalNext = totalNext + TOT_W'(cntNext[i]);
            busy_mask[i] = (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            outstanding <= totalNext;
            err         <= err | (|underflowVec);
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;
    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_rs1_used;
    logic        issue_rs2_used;
    logic [4:0]  issue_rd;
    logic        issue_rd_we;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        kill_valid;
    logic [4:0]  kill_rd;
    logic [31:0] busy_mask;
    logic [6:0]  outstanding;
    logic        err;

    int nVec  = 0;
    int nMiss = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.REGS(32), .CNT_W(2), .TOT_W(7)) dut (
        .clk            (clk),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_rs1_used (issue_rs1_used),
        .issue_rs2_used (issue_rs2_used),
        .issue_rd       (issue_rd),
        .issue_rd_we    (issue_rd_we),
        .issue_ready    (issue_ready),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .kill_valid     (kill_valid),
        .kill_rd        (kill_rd),
        .busy_mask      (busy_mask),
        .outstanding    (outstanding),
        .err            (err)
    );

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0;
        issue_rs1_used = 0; issue_rs2_used = 0;
        issue_rd = 0; issue_rd_we = 0;
        wb_valid = 0; wb_rd = 0; kill_valid = 0; kill_rd = 0;
    endtask

    // Advance one edge, then let combinational outputs of newly driven inputs settle.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_wr(input logic [4:0] rd);
        idle();
        issue_valid = 1; issue_rd = rd; issue_rd_we = 1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        cycle();
        #2;
        nVec++; if (issue_ready !== 1'b0) begin nMiss++; $display("FAIL reset_ready got=%b exp=0", issue_ready); end
        nVec++; if (busy_mask !== 32'h0) begin nMiss++; $display("FAIL reset_busy got=%h exp=0", busy_mask); end
        nVec++; if (outstanding !== 7'd0) begin nMiss++; $display("FAIL reset_outst got=%0d exp=0", outstanding); end
        nVec++; if (err !== 1'b0) begin nMiss++; $display("FAIL reset_err got=%b exp=0", err); end
        reset = 0;
        cycle();
    endtask

    task automatic test_raw();
        issue_wr(5);
        #2;
        nVec++; if (issue_ready !== 1'b1) begin nMiss++; $display("FAIL raw_first_ready got=%b exp=1", issue_ready); end
        cycle();
        idle(); issue_valid = 1; issue_rs1 = 5; issue_rs1_used = 1;
        #2;
        nVec++; if (issue_ready !== 1'b0) begin nMiss++; $display("FAIL raw_stall got=%b exp=0", issue_ready); end
        nVec++; if (busy_mask !== 32'h0000_0020) begin nMiss++; $display("FAIL raw_busy got=%h exp=00000020", busy_mask); end
        nVec++; if (outstanding !== 7'd1) begin nMiss++; $display("FAIL raw_outst got=%0d exp=1", outstanding); end
        cycle();
        wb_valid = 1; wb_rd = 5;
        #2;
        nVec++; if (issue_ready !== 1'b0) begin nMiss++; $display("FAIL raw_no_bypass got=%b exp=0", issue_ready); end
        cycle();
        wb_valid = 0;
        #2;
        nVec++; if (issue_ready !== 1'b1) begin nMiss++; $display("FAIL raw_release got=%b exp=1", issue_ready); end
        nVec++; if (busy_mask !== 32'h0) begin nMiss++; $display("FAIL raw_busy_clear got=%h exp=0", busy_mask); end
        nVec++; if (outstanding !== 7'd0) begin nMiss++; $display("FAIL raw_outst_clear got=%0d exp=0", outstanding); end
        cycle();
        // rs2 hazard, and an unused source pointing at a busy register
        issue_wr(20);
        cycle();
        idle(); issue_valid = 1; issue_rs1 = 20; issue_rs2 = 0; issue_rs2_used = 1;
        #2;
        nVec++; if (issue_ready !== 1'b1) begin nMiss++; $display("FAIL rs1_unused got=%b exp=1", issue_ready); end
        issue_rs2 = 20;
        #1;
        nVec++; if (issue_ready !== 1'b0) begin nMiss++; $display("FAIL rs2_hazard got=%b exp=0", issue_ready); end
        idle(); kill_valid = 1; kill_rd = 20;
        cycle();
        idle();
        #2;
        nVec++; if (outstanding !== 7'd0 || err !== 1'b0) begin nMiss++; $display("FAIL kill_clean got=%0d/%b exp=0/0", outstanding, err); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            issue_wr(7);
            #2;
            nVec++; if (issue_ready !== 1'b1) begin nMiss++; $display("FAIL sat_issue%0d got=%b exp=1", k, issue_ready); end
            cycle();
        end
        issue_wr(7);
        #2;
        nVec++; if (issue_ready !== 1'b0) begin nMiss++; $display("FAIL sat_blocked got=%b exp=0", issue_ready); end
        nVec++; if (outstanding !== 7'd3) begin nMiss++; $display("FAIL sat_outst got=%0d exp=3", outstanding); end
        wb_valid = 1; wb_rd = 7;
        #1;
        nVec++; if (issue_ready !== 1'b0) begin nMiss++; $display("FAIL sat_wb_same got=%b exp=0", issue_ready); end
        cycle();
        wb_valid = 0;
        #2;
        nVec++; if (outstanding !== 7'd2) begin nMiss++; $display("FAIL sat_after_wb got=%0d exp=2", outstanding); end
        nVec++; if (issue_ready !== 1'b1) begin nMiss++; $display("FAIL sat_accept got=%b exp=1", issue_ready); end
        cycle();
        idle();
        #2;
        nVec++; if (outstanding !== 7'd3 || busy_mask !== 32'h0000_0080) begin
            nMiss++; $display("FAIL sat_net got=%0d/%h exp=3/00000080", outstanding, busy_mask);
        end
        wb_valid = 1; wb_rd = 7;
        repeat (3) cycle();
        idle();
        #2;
        nVec++; if (outstanding !== 7'd0 || err !== 1'b0) begin nMiss++; $display("FAIL sat_drain got=%0d/%b exp=0/0", outstanding, err); end
    endtask

    task automatic test_zero_reg();
        for (int k = 0; k < 3; k++) begin
            issue_wr(31); issue_rs1 = 31; issue_rs2 = 31; issue_rs1_used = 1; issue_rs2_used = 1;
            #2;
            nVec++; if (issue_ready !== 1'b1) begin nMiss++; $display("FAIL zero_ready%0d got=%b exp=1", k, issue_ready); end
            cycle();
        end
        idle();
        #2;
        nVec++; if (busy_mask !== 32'h0 || outstanding !== 7'd0) begin
            nMiss++; $display("FAIL zero_busy got=%h/%0d exp=0/0", busy_mask, outstanding);
        end
        wb_valid = 1; wb_rd = 31; kill_valid = 1; kill_rd = 31;
        cycle();
        idle();
        #2;
        nVec++; if (err !== 1'b0) begin nMiss++; $display("FAIL zero_wb_err got=%b exp=0", err); end
    endtask

    task automatic test_net();
        issue_wr(3); cycle();
        issue_wr(3); cycle();
        issue_wr(3); wb_valid = 1; wb_rd = 3;
        #2;
        nVec++; if (issue_ready !== 1'b1) begin nMiss++; $display("FAIL net_ready got=%b exp=1", issue_ready); end
        cycle();
        idle();
        #2;
        nVec++; if (outstanding !== 7'd2 || busy_mask !== 32'h0000_0008) begin
            nMiss++; $display("FAIL net_count got=%0d/%h exp=2/00000008", outstanding, busy_mask);
        end
        wb_valid = 1; wb_rd = 3; kill_valid = 1; kill_rd = 3;
        cycle();
        idle();
        #2;
        nVec++; if (outstanding !== 7'd0 || err !== 1'b0) begin nMiss++; $display("FAIL net_dual_dec got=%0d/%b exp=0/0", outstanding, err); end
    endtask

    task automatic test_underflow();
        issue_wr(9); cycle();
        idle(); wb_valid = 1; wb_rd = 9; kill_valid = 1; kill_rd = 9;
        cycle();
        idle();
        #2;
        nVec++; if (busy_mask !== 32'h0 || outstanding !== 7'd0) begin
            nMiss++; $display("FAIL uf_count got=%h/%0d exp=0/0", busy_mask, outstanding);
        end
        nVec++; if (err !== 1'b1) begin nMiss++; $display("FAIL uf_err got=%b exp=1", err); end
        cycle();
        nVec++; if (err !== 1'b1) begin nMiss++; $display("FAIL uf_sticky got=%b exp=1", err); end
    endtask

    task automatic test_mid_reset();
        issue_wr(10); cycle();
        issue_wr(11); cycle();
        issue_wr(12); cycle();
        idle();
        #2;
        nVec++; if (busy_mask !== 32'h0000_1C00 || outstanding !== 7'd3) begin
            nMiss++; $display("FAIL mr_build got=%h/%0d exp=00001c00/3", busy_mask, outstanding);
        end
        reset = 1; issue_valid = 1; issue_rd = 13; issue_rd_we = 1;
        #1;
        nVec++; if (issue_ready !== 1'b0) begin nMiss++; $display("FAIL mr_ready_in_reset got=%b exp=0", issue_ready); end
        cycle();
        reset = 0; idle();
        issue_valid = 1; issue_rs1 = 10; issue_rs1_used = 1;
        #2;
        nVec++; if (busy_mask !== 32'h0 || outstanding !== 7'd0 || err !== 1'b0) begin
            nMiss++; $display("FAIL mr_cleared got=%h/%0d/%b exp=0/0/0", busy_mask, outstanding, err);
        end
        nVec++; if (issue_ready !== 1'b1) begin nMiss++; $display("FAIL mr_ready_after got=%b exp=1", issue_ready); end
        cycle();
        idle(); wb_valid = 1; wb_rd = 11;
        cycle();
        idle();
        #2;
        nVec++; if (err !== 1'b1 || outstanding !== 7'd0) begin nMiss++; $display("FAIL mr_stale_wb got=%b/%0d exp=1/0", err, outstanding); end
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_raw();
        test_saturation();
        test_zero_reg();
        test_net();
        test_underflow();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end
endmodule
